// File: rtl/lab_pkg.sv
// Shared definitions for the plot sink: screen geometry, FSM state encoding and pixel record.
package lab_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
    localparam int FB_AW    = 15;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SCAN  = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    // Linear frame-buffer address, row-major with x fastest.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x,
                                                 input logic [6:0] y,
                                                 input logic [FB_AW-1:0] row_w);
        return 15'(y) * row_w + 15'(x);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port, read-first.
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic          re_i,
    input  logic [AW-1:0] ra_i,
    output logic [DW-1:0] rd_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_q;

    // Contents are deliberately not reset; the read sees the pre-write value on a collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
        if (re_i) begin
            rd_q <= mem_q[ra_i];
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/plot_sink.sv
// plot_sink: captures in-bounds plots, clears the frame buffer to black and scans it out in raster order.
// Build option PLOT_SINK_OOB_CNT_EN enables the out-of-bounds plot counter (tied to 0 otherwise).
module plot_sink
    import lab_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clr_start,
    input  logic        scan_start,
    output logic        busy,
    output logic        clr_done,
    output logic        scan_valid,
    output logic [7:0]  scan_x,
    output logic [6:0]  scan_y,
    output logic [2:0]  scan_colour,
    output logic        scan_done,
    output logic [14:0] plot_count,
    output logic [7:0]  oob_count
);

    localparam int          DEPTH    = SCREEN_W * SCREEN_H;
    localparam logic [7:0]  X_LIM    = 8'(SCREEN_W);
    localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [6:0]  Y_LIM    = 7'(SCREEN_H);
    localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 1);
    localparam logic [14:0] A_LAST   = 15'(DEPTH - 1);
    localparam logic [14:0] ROW_W    = 15'(SCREEN_W);
    localparam logic [14:0] PLOT_MAX = 15'h7FFF;

    sink_state_t state_q, state_d;

    logic        plot_ok_s;
    logic        start_clr_s, start_scan_s, clr_wr_s;
    logic        wr_en_s;
    logic [14:0] wr_addr_s;
    logic [2:0]  wr_data_s;
    logic [2:0]  rd_data_s;

    logic [14:0] clr_addr_q, clr_addr_d;
    logic        clr_done_q, clr_done_d;
    logic        busy_q, busy_d;

    logic        issue_q, issue_d;
    logic [7:0]  sx_q, sx_d;
    logic [6:0]  sy_q, sy_d;
    logic [14:0] scan_addr_q, scan_addr_d;
    logic        p1_valid_q, p1_last_q, p1_last_d;
    logic [7:0]  p1_x_q;
    logic [6:0]  p1_y_q;

    logic        scan_valid_q, scan_done_q;
    pixel_t      scan_q;
    logic [14:0] plot_count_q, plot_count_d;

    assign plot_ok_s = vga_plot && (vga_x < X_LIM) && (vga_y < Y_LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a clear request wins over a simultaneous scan request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                end else if (scan_start) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (clr_done_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_SCAN: begin
                if (scan_done_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath decode: write-port arbitration, clear and scan sequencing, plot statistics
    always_comb begin
        start_clr_s  = (state_q == S_IDLE) && clr_start;
        start_scan_s = (state_q == S_IDLE) && !clr_start && scan_start;
        // An accepted plot owns the single write port, so the clear step stalls that cycle.
        clr_wr_s     = (state_q == S_CLEAR) && !clr_done_q && !plot_ok_s;
        busy_d       = (state_d != S_IDLE);
        clr_done_d   = clr_wr_s && (clr_addr_q == A_LAST);

        wr_en_s   = plot_ok_s || clr_wr_s;
        if (plot_ok_s) begin
            wr_addr_s = fb_addr(vga_x, vga_y, ROW_W);
            wr_data_s = vga_colour;
        end else begin
            wr_addr_s = clr_addr_q;
            wr_data_s = 3'd0;
        end

        if (start_clr_s) begin
            clr_addr_d = 15'd0;
        end else if (clr_wr_s) begin
            clr_addr_d = clr_addr_q + 15'd1;
        end else begin
            clr_addr_d = clr_addr_q;
        end

        issue_d     = issue_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        scan_addr_d = scan_addr_q;
        p1_last_d   = issue_q && (sx_q == X_LAST) && (sy_q == Y_LAST);
        if (start_scan_s) begin
            issue_d     = 1'b1;
            sx_d        = 8'd0;
            sy_d        = 7'd0;
            scan_addr_d = 15'd0;
        end else if (issue_q) begin
            scan_addr_d = scan_addr_q + 15'd1;
            if (sx_q == X_LAST) begin
                sx_d = 8'd0;
                if (sy_q == Y_LAST) begin
                    sy_d    = 7'd0;
                    issue_d = 1'b0;
                end else begin
                    sy_d = sy_q + 7'd1;
                end
            end else begin
                sx_d = sx_q + 8'd1;
            end
        end else begin
            issue_d = 1'b0;
        end

        if (start_clr_s) begin
            plot_count_d = 15'd0;
        end else if (plot_ok_s && (plot_count_q != PLOT_MAX)) begin
            plot_count_d = plot_count_q + 15'd1;
        end else begin
            plot_count_d = plot_count_q;
        end
    end

    // Sequencing registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr_q   <= 15'd0;
            clr_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            issue_q      <= 1'b0;
            sx_q         <= 8'd0;
            sy_q         <= 7'd0;
            scan_addr_q  <= 15'd0;
            p1_valid_q   <= 1'b0;
            p1_last_q    <= 1'b0;
            p1_x_q       <= 8'd0;
            p1_y_q       <= 7'd0;
            scan_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_q       <= '0;
            plot_count_q <= 15'd0;
        end else begin
            clr_addr_q   <= clr_addr_d;
            clr_done_q   <= clr_done_d;
            busy_q       <= busy_d;
            issue_q      <= issue_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            scan_addr_q  <= scan_addr_d;
            p1_valid_q   <= issue_q;
            p1_last_q    <= p1_last_d;
            p1_x_q       <= sx_q;
            p1_y_q       <= sy_q;
            scan_valid_q <= p1_valid_q;
            scan_done_q  <= p1_last_q;
            if (p1_valid_q) begin
                scan_q <= '{x: p1_x_q, y: p1_y_q, colour: rd_data_s};
            end
            plot_count_q <= plot_count_d;
        end
    end

`ifdef PLOT_SINK_OOB_CNT_EN
    logic       oob_s;
    logic [7:0] oob_count_q;

    assign oob_s = vga_plot && !plot_ok_s;

    // Saturating count of rejected plots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_count_q <= 8'd0;
        end else if (oob_s && (oob_count_q != 8'hFF)) begin
            oob_count_q <= oob_count_q + 8'd1;
        end
    end

    assign oob_count = oob_count_q;
`else
    assign oob_count = 8'd0;
`endif

    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (15),
        .DW    (3)
    ) u_fb_ram (
        .clk_i (clk),
        .we_i  (wr_en_s),
        .wa_i  (wr_addr_s),
        .wd_i  (wr_data_s),
        .re_i  (issue_q),
        .ra_i  (scan_addr_q),
        .rd_o  (rd_data_s)
    );

    assign busy        = busy_q;
    assign clr_done    = clr_done_q;
    assign scan_valid  = scan_valid_q;
    assign scan_x      = scan_q.x;
    assign scan_y      = scan_q.y;
    assign scan_colour = scan_q.colour;
    assign scan_done   = scan_done_q;
    assign plot_count  = plot_count_q;

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: frame-buffer model plus per-cycle compare and pinned literal checks.
module tb_plot_sink;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int FB_N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  vga_x = 8'd0;
    logic [6:0]  vga_y = 7'd0;
    logic [2:0]  vga_colour = 3'd0;
    logic        vga_plot = 1'b0;
    logic        clr_start = 1'b0;
    logic        scan_start = 1'b0;
    logic        busy, clr_done, scan_valid, scan_done;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_colour;
    logic [14:0] plot_count;
    logic [7:0]  oob_count;

    int n_chk = 0;
    int n_err = 0;

    int m_fb [FB_N];
    int cap  [FB_N];
    int m_plot = 0;
    int m_oob  = 0;
    bit exp_busy = 1'b0;
    bit scan_on = 1'b0;
    int scan_e0 = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int beats = 0;
    int nz = 0;

`ifdef PLOT_SINK_OOB_CNT_EN
    localparam int OOB_EXP = 3;
`else
    localparam int OOB_EXP = 0;
`endif

    plot_sink #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .clr_start(clr_start), .scan_start(scan_start),
        .busy(busy), .clr_done(clr_done), .scan_valid(scan_valid), .scan_x(scan_x),
        .scan_y(scan_y), .scan_colour(scan_colour), .scan_done(scan_done),
        .plot_count(plot_count), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            bit ev;
            k  = cyc - scan_e0 - 2;
            ev = scan_on && (k >= 0) && (k < FB_N);
            check("scan_valid", scan_valid, ev);
            check("scan_done", scan_done, ev && (k == FB_N - 1));
            check("busy", busy, exp_busy);
            check("plot_count", plot_count, m_plot);
            check("oob_count", oob_count, m_oob);
            if (ev && scan_valid) begin
                check("scan_x", scan_x, k % W);
                check("scan_y", scan_y, k / W);
                check("scan_colour", scan_colour, m_fb[k]);
            end
            if (scan_valid) begin
                beats++;
                if (scan_colour != 3'd0) nz++;
                if ((int'(scan_y) * W + int'(scan_x)) < FB_N)
                    cap[int'(scan_y) * W + int'(scan_x)] = int'(scan_colour);
            end
        end
    end

    // Plot outside any clear: model writes the pixel or counts the rejection
    task automatic plot(input int x, input int y, input int c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
        if (x < W && y < H) begin
            m_fb[y * W + x] = c;
            m_plot++;
        end else begin
            m_oob += (OOB_EXP != 0) ? 1 : 0;
        end
    endtask

    // Clear with one in-bounds plot at clear cycle plot_at and an ignored scan_start at cycle 10
    task automatic run_clear(input bit with_scan, input int plot_at, input int px, input int py,
                             input int pc, input int exp_len);
        int cleared;
        int done_at;
        bit did;
        clr_start = 1'b1; scan_start = with_scan;
        tick();
        clr_start = 1'b0; scan_start = 1'b0;
        exp_busy = 1'b1;
        m_plot = 0;
        for (int i = 0; i < FB_N; i++) m_fb[i] = 0;
        cleared = 0;
        done_at = -1;
        for (int n = 1; n <= FB_N + 100 && done_at < 0; n++) begin
            did = 1'b0;
            if (n == plot_at) begin
                vga_x = 8'(px); vga_y = 7'(py); vga_colour = 3'(pc); vga_plot = 1'b1;
                did = 1'b1;
            end
            if (n == 10) scan_start = 1'b1;
            tick();
            vga_plot = 1'b0; scan_start = 1'b0;
            if (did) begin
                // pixels already swept keep the plot; the rest are blackened later
                if (py * W + px < cleared) m_fb[py * W + px] = pc;
                m_plot++;
            end else if (cleared < FB_N) begin
                cleared++;
            end
            if (clr_done) done_at = n;
        end
        check("clr_done_cycle", done_at, exp_len);
        tick();
        check("clr_done_pulse_width", clr_done, 1'b0);
        exp_busy = 1'b0;
        tick();
    endtask

    task automatic run_scan(input int exp_nz);
        beats = 0; nz = 0;
        for (int i = 0; i < FB_N; i++) cap[i] = -1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_e0 = cyc; scan_on = 1'b1; exp_busy = 1'b1;
        repeat (FB_N + 1) tick();
        tick();
        exp_busy = 1'b0;
        tick();
        scan_on = 1'b0;
        tick();
        check("scan_beats", beats, FB_N);
        check("scan_nonzero", nz, exp_nz);
    endtask

    initial begin
        for (int i = 0; i < FB_N; i++) m_fb[i] = 0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_scan_valid", scan_valid, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_scan_x", scan_x, 8'd0);
        check("rst_scan_y", scan_y, 7'd0);
        check("rst_scan_colour", scan_colour, 3'd0);
        check("rst_plot_count", plot_count, 15'd0);
        check("rst_oob_count", oob_count, 8'd0);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;

        // Clear with plot to (10,0) at cycle 5: not yet swept, ends black, one cycle late
        run_clear(1'b0, 5, 10, 0, 6, 19201);
        check("plot_count_after_clear_a", plot_count, 15'd1);

        // Reset at scan cycle 100 aborts without a done pulse
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_e0 = cyc; scan_on = 1'b1; exp_busy = 1'b1;
        repeat (99) tick();
        rst = 1'b1; scan_on = 1'b0; exp_busy = 1'b0; m_plot = 0; m_oob = 0;
        #1;
        check("midscan_rst_busy", busy, 1'b0);
        check("midscan_rst_valid", scan_valid, 1'b0);
        check("midscan_rst_done", scan_done, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Full scan of cleared buffer: all black including the overwritten (10,0)
        run_scan(0);
        check("pix_10_0_black", cap[10], 0);
        check("pix_0_0_black", cap[0], 0);

        // Simultaneous starts: clear wins, no beats; plot to (2,0) at cycle 5 survives
        beats = 0;
        run_clear(1'b1, 5, 2, 0, 6, 19201);
        check("no_beats_during_clear", beats, 0);
        check("plot_count_after_clear_d", plot_count, 15'd1);

        // Corner plots then out-of-bounds plots
        plot(0, 0, 3);
        plot(159, 119, 5);
        plot(80, 60, 7);
        tick();
        check("plot_count_corners", plot_count, 15'd4);
        plot(160, 0, 1);
        plot(0, 120, 2);
        plot(255, 127, 4);
        tick();
        check("plot_count_after_oob", plot_count, 15'd4);
        check("oob_count_after_oob", oob_count, OOB_EXP);
        run_scan(4);
        check("pix_0_0", cap[0], 3);
        check("pix_159_119", cap[19199], 5);
        check("pix_80_60", cap[9680], 7);
        check("pix_2_0", cap[2], 6);
        check("pix_160_0_wrap_untouched", cap[160], 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
